mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port synaptic-weight memory between N_REQ requesters, for example the neuron-update engine and the reward/STDP learning unit.
- Supports three operations: read, write, and atomic saturating add (read-modify-write) for reward-driven weight updates.
- Sits between the requesters and the Memory block, driving that block's we/addr/wdata and consuming its rdata.
- Non-pipelined: at most one operation is in flight at a time.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Requester-side bus of the synaptic-weight memory arbiter. All requesters
// share one interface instance; per-requester fields are packed side by side
// (requester i occupies slice i of each vector).
//
//   req_valid  [N_REQ]         request valid, one bit per requester
//   req_ready  [N_REQ]         accept, one-hot or zero
//   req_op     [2*N_REQ]       00 read, 01 write, 10 saturating add, 11 read
//   req_addr   [ADDR_W*N_REQ]  weight address
//   req_wdata  [DW*N_REQ]      write data, or signed delta for add
//   rsp_valid  [N_REQ]         one-cycle response strobe to the owner
//   rsp_data   [DW]            read data / post-add value, shared
//
// modport master: requester side; modport slave: arbiter side.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DW     = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [2*N_REQ-1:0]      req_op;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [DW*N_REQ-1:0]     req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DW-1:0]           rsp_data;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter and sequencer sharing one single-port synaptic-weight
// memory between N_REQ requesters. Supports read, write and an atomic
// saturating add (read-modify-write). One operation in flight at a time.
//
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        requester bus (mem_arbiter_if.slave)
//   busy       high whenever the sequencer is not idle
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid the cycle after the address (read-first)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAPT = 2'd1;
    localparam logic [1:0] S_RMW  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
    localparam logic [DW-1:0]    SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]    SAT_MIN   = {1'b1, {(DW-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [1:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [DW:0]       sum_ext;
    logic [DW-1:0]     sat_sum;
    logic [N_REQ-1:0]  req_ready_c;
    logic [N_REQ-1:0]  rsp_valid_c;

    // Search starts one past the last winner and wraps, so the most recent
    // winner has lowest priority. Returns {found, index}.
    function automatic logic [IDX_W:0] pick_grant(input logic [N_REQ-1:0] valid,
                                                  input logic [IDX_W-1:0] last);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!found && valid[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        return {found, idx};
    endfunction

    assign {grant_found, grant_idx} = pick_grant(bus.req_valid, last_q);
    assign sel_op    = bus.req_op[2*grant_idx +: 2];
    assign sel_addr  = bus.req_addr[ADDR_W*grant_idx +: ADDR_W];
    assign sel_wdata = bus.req_wdata[DW*grant_idx +: DW];

    // One extra bit of headroom; overflow shows as the top two bits differing.
    assign sum_ext = {mem_rdata[DW-1], mem_rdata} + {wdata_q[DW-1], wdata_q};
    assign sat_sum = (sum_ext[DW] != sum_ext[DW-1]) ? (sum_ext[DW] ? SAT_MIN : SAT_MAX)
                                                   : sum_ext[DW-1:0];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        mem_we      = 1'b0;
        mem_addr    = mem_addr_q;
        mem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                // The address is presented in the accept cycle so read data
                // arrives exactly when CAPT/RMW need it.
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    mem_addr  = sel_addr;
                    mem_wdata = sel_wdata;
                    mem_we    = (sel_op == OP_WRITE);
                    gnt_d     = grant_idx;
                    last_d    = grant_idx;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    if (sel_op == OP_WRITE) begin
                        state_d = S_RESP;
                    end else if (sel_op == OP_ADD) begin
                        state_d = S_RMW;
                    end else begin
                        state_d = S_CAPT;
                    end
                end
            end
            S_CAPT: begin
                mem_addr   = addr_q;
                rsp_data_d = mem_rdata;
                state_d    = S_RESP;
            end
            S_RMW: begin
                mem_addr   = addr_q;
                mem_we     = 1'b1;
                mem_wdata  = sat_sum;
                rsp_data_d = sat_sum;
                state_d    = S_RESP;
            end
            default: begin
                mem_addr           = addr_q;
                rsp_valid_c[gnt_q] = 1'b1;
                state_d            = S_IDLE;
            end
        endcase

        // A reset arriving mid-operation must not commit the write-back or
        // strobe a response for the abandoned operation.
        if (rst) begin
            mem_we      = 1'b0;
            req_ready_c = '0;
            rsp_valid_c = '0;
        end

        mem_addr_d = mem_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_INIT;
            gnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with a behavioural read-first memory.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int N_REQ  = 2;
    localparam int ADDR_W = 4;
    localparam int DW     = 8;

    logic              clk;
    logic              rst;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [DW-1:0]     mem [0:(1<<ADDR_W)-1];

    int n_vectors;
    int n_miscompares;

    mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DW(DW)) bus ();

    mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous memory, read-first.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Raises the valid of requester r with the given fields; other requesters
    // keep whatever they are driving.
    task automatic applyStimulus(input int r, input logic [1:0] op,
                                 input logic [ADDR_W-1:0] addr, input logic [DW-1:0] wd);
        bus.req_valid[r]                = 1'b1;
        bus.req_op[2*r +: 2]            = op;
        bus.req_addr[ADDR_W*r +: ADDR_W] = addr;
        bus.req_wdata[DW*r +: DW]       = wd;
    endtask

    task automatic applyReset();
        rst           = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Single request from requester r; checks accept, latency, strobe and data.
    task automatic runOp(input string tag, input int r, input logic [1:0] op,
                         input logic [ADDR_W-1:0] addr, input logic [DW-1:0] wd,
                         input int exp_lat, input logic check_data,
                         input logic [DW-1:0] exp_data);
        int lat;
        @(negedge clk);
        bus.req_valid = '0;
        applyStimulus(r, op, addr, wd);
        #1;
        checkOutput({tag, ".ready"}, 32'(bus.req_ready), 32'(1 << r));
        checkOutput({tag, ".we"}, 32'(mem_we), 32'(op == 2'b01));
        @(negedge clk);
        bus.req_valid = '0;
        lat = 1;
        while (bus.rsp_valid == '0 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << r));
        if (check_data) begin
            checkOutput({tag, ".data"}, 32'(bus.rsp_data), 32'(exp_data));
        end
    endtask

    initial begin
        int grant_order [4];
        int n_grants;

        n_vectors     = 0;
        n_miscompares = 0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst           = 1'b1;

        // Reset state
        applyReset();
        #1;
        checkOutput("rst.ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst.rsp_data", 32'(bus.rsp_data), 32'h0);
        checkOutput("rst.busy", 32'(busy), 32'h0);
        checkOutput("rst.we", 32'(mem_we), 32'h0);

        // Test 1: write then read back from requester 0
        runOp("t1_wr", 0, 2'b01, 4'd3, 8'h25, 1, 1'b0, 8'h00);
        runOp("t1_rd", 0, 2'b00, 4'd3, 8'h00, 2, 1'b1, 8'h25);

        // Test 2: both requesters continuously valid -> alternate 0,1,0,1
        applyReset();
        applyStimulus(0, 2'b00, 4'd3, 8'h00);
        applyStimulus(1, 2'b00, 4'd3, 8'h00);
        n_grants = 0;
        for (int i = 0; i < 4; i++) grant_order[i] = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checkOutput("t2.onehot", 32'($countones(bus.req_ready) <= 1), 32'h1);
            if (bus.req_ready != '0 && n_grants < 4) begin
                grant_order[n_grants] = bus.req_ready[1] ? 1 : 0;
                n_grants++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        checkOutput("t2.n_grants", 32'(n_grants), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2.order", 32'(grant_order[i]), 32'(i % 2));
        end

        // Test 3: saturating add, both clamps and a plain in-range add
        runOp("t3_wr5", 0, 2'b01, 4'd5, 8'd120, 1, 1'b0, 8'h00);
        runOp("t3_wr6", 0, 2'b01, 4'd6, 8'h88, 1, 1'b0, 8'h00);
        runOp("t3_wr7", 0, 2'b01, 4'd7, 8'd10, 1, 1'b0, 8'h00);
        runOp("t3_add5", 0, 2'b10, 4'd5, 8'd20, 2, 1'b1, 8'h7F);
        checkOutput("t3.mem5", 32'(mem[5]), 32'h7F);
        runOp("t3_add6", 0, 2'b10, 4'd6, 8'hEC, 2, 1'b1, 8'h80);
        checkOutput("t3.mem6", 32'(mem[6]), 32'h80);
        runOp("t3_add7", 0, 2'b10, 4'd7, 8'hFD, 2, 1'b1, 8'h07);
        checkOutput("t3.mem7", 32'(mem[7]), 32'h07);

        // Test 4: add from requester 0 while requester 1 waits to read it
        runOp("t4_wr9", 1, 2'b01, 4'd9, 8'h30, 1, 1'b0, 8'h00);
        @(negedge clk);
        bus.req_valid = '0;
        applyStimulus(0, 2'b10, 4'd9, 8'h05);
        applyStimulus(1, 2'b00, 4'd9, 8'h00);
        #1;
        checkOutput("t4.T.ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        checkOutput("t4.T1.ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("t4.T2.ready", 32'(bus.req_ready), 32'h0);
        checkOutput("t4.T2.rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("t4.T2.data", 32'(bus.rsp_data), 32'h35);
        @(negedge clk);
        #1;
        checkOutput("t4.T3.ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        checkOutput("t4.rd.rsp_valid", 32'(bus.rsp_valid), 32'h2);
        checkOutput("t4.rd.data", 32'(bus.rsp_data), 32'h35);

        // Test 5: reset during the RMW cycle abandons the add
        runOp("t5_wr8", 0, 2'b01, 4'd8, 8'h10, 1, 1'b0, 8'h00);
        @(negedge clk);
        bus.req_valid = '0;
        applyStimulus(0, 2'b10, 4'd8, 8'h05);
        #1;
        checkOutput("t5.ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b1;
        #1;
        checkOutput("t5.rmw.busy", 32'(busy), 32'h1);
        checkOutput("t5.rmw.we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t5.busy", 32'(busy), 32'h0);
        checkOutput("t5.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("t5.ready", 32'(bus.req_ready), 32'h0);
        checkOutput("t5.rsp_data", 32'(bus.rsp_data), 32'h0);
        checkOutput("t5.we", 32'(mem_we), 32'h0);
        checkOutput("t5.addr", 32'(mem_addr), 32'h0);
        checkOutput("t5.wdata", 32'(mem_wdata), 32'h0);
        checkOutput("t5.mem8", 32'(mem[8]), 32'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5.no_rsp", 32'(bus.rsp_valid), 32'h0);
        end

        // Test 6: op 11 behaves as a read; idle bus stays quiet
        runOp("t6_op11", 1, 2'b11, 4'd3, 8'h00, 2, 1'b1, 8'h25);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("t6.idle.we", 32'(mem_we), 32'h0);
            checkOutput("t6.idle.ready", 32'(bus.req_ready), 32'h0);
        end
        checkOutput("t6.idle.addr", 32'(mem_addr), 32'h3);
        checkOutput("t6.idle.busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
